// File: rtl/vc_rr_arbiter.sv
// vc_rr_arbiter: round-robin drain of four VC FIFOs into one downstream FIFO,
// tagging each word with its VC index and throttling on downstream almost_full/full.
module vc_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int NVC   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NVC-1:0]       empty_in,
    input  logic [NVC*WIDTH-1:0] q_in,
    input  logic                 af_down,
    input  logic                 full_down,
    output logic [NVC-1:0]       pop_out,
    output logic [WIDTH-1:0]     data_out,
    output logic [1:0]           vc_out,
    output logic                 push_out,
    output logic [7:0]           pkt_count,
    output logic                 error,
    output logic                 idle
);
    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;
    state_t state_q, state_d;
    logic [NVC-1:0] pop_q, pop_d;
    logic [1:0] last_q, gnt, cand, pop_idx;
    logic [WIDTH-1:0] data_q;
    logic [1:0] vc_q;
    logic push_q, err_q, found, any_req, grant_ok, popped;
    logic [7:0] pkt_q;
    assign any_req  = ~&empty_in;
    assign grant_ok = any_req & ~af_down & ~full_down;
    assign popped   = |pop_q;
    assign pop_idx  = {pop_q[3] | pop_q[2], pop_q[3] | pop_q[1]};
    // search starts one past the last grant so every VC gets a turn
    always_comb begin
        gnt   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && !empty_in[cand]) begin
                gnt   = cand;
                found = 1'b1;
            end
        end
        pop_d = grant_ok ? NVC'(1) << gnt : '0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = grant_ok ? ACTIVE : (state_q != IDLE && any_req) ? STALL : IDLE;
    end
    always_comb begin
        idle = (state_q == IDLE) & ~push_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_q  <= '0;
            last_q <= 2'd3;
            data_q <= '0;
            vc_q   <= '0;
            push_q <= 1'b0;
            err_q  <= 1'b0;
            pkt_q  <= '0;
        end else begin
            pop_q  <= pop_d;
            last_q <= grant_ok ? gnt : last_q;
            // a capture against a full downstream FIFO drops the word
            push_q <= popped & ~full_down;
            err_q  <= err_q | (popped & full_down);
            pkt_q  <= pkt_q + {7'd0, push_q};
            if (popped) begin
                data_q <= q_in[pop_idx*WIDTH +: WIDTH];
                vc_q   <= pop_idx;
            end
        end
    end
    assign pop_out   = pop_q;
    assign data_out  = data_q;
    assign vc_out    = vc_q;
    assign push_out  = push_q;
    assign pkt_count = pkt_q;
    assign error     = err_q;
endmodule
